cpu_simple_imem_loader: RTL and testbench
=========================================

Name: cpu_simple_imem_loader

Overview:
- Write-side counterpart to cpu_simple's instruction fetch.
- Receives a framed byte stream (valid/ready), writes the 16x8 instruction memory, and holds the CPU in reset until a frame with a good checksum has loaded.
- Provides the combinational fetch port that cpu_simple reads with its PC.
- Sits between the host/bench byte source and cpu_simple.

Parameters:
- ADDR_W, 4, instruction address width; depth = 2**ADDR_W.
- DATA_W, 8, instruction width.
- SYNC_BYTE, 8'hA5, frame header value.
- TIMEOUT, 64, idle-cycle limit inside a frame (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  stream byte valid.
- in_data  in  DATA_W  stream byte.
- in_ready  out  1  loader accepts byte; transfer = in_valid & in_ready at rising clk.
- load_start  in  1  one-cycle pulse; restarts loading from DONE or ERR.
- fetch_pc  in  ADDR_W  CPU program counter.
- fetch_inst  out  DATA_W  mem[fetch_pc], combinational.
- cpu_rst  out  1  active-high reset to cpu_simple; 1 until load succeeds.
- load_done  out  1  frame loaded, checksum OK.
- load_err  out  1  frame rejected.

Behaviour:
- Reset (rst=0, async):
  - state=HDR, all 16 memory words=0, write pointer=0, length=0, checksum acc=0.
  - cpu_rst=1, load_done=0, load_err=0.
- Frame format: SYNC_BYTE, LEN, LEN data bytes, CSUM.
  - LEN must be 1..16.
  - CSUM = XOR of all data bytes.
- States and transitions:
  - HDR: in_ready=1. Byte==SYNC_BYTE -> LEN. Other bytes are silently discarded.
  - LEN: in_ready=1. Byte 1..16 -> latch length, clear pointer and acc, go to DATA. Byte 0 or >16 -> ERR.
  - DATA: in_ready=1. Each accepted byte writes mem[ptr] on the same edge, acc ^= byte, ptr++. Accepting the byte with ptr==length-1 -> CSUM.
  - CSUM: in_ready=1. Byte==acc -> DONE; otherwise -> ERR.
  - DONE: in_ready=0, load_done=1, cpu_rst=0. Both outputs are registered and assert on the edge after the CSUM byte is accepted.
  - ERR: in_ready=0, load_err=1, cpu_rst=1.
- load_start:
  - In DONE or ERR: -> HDR; clears load_done and load_err; cpu_rst=1 on the next edge.
  - Ignored in all other states.
- Memory contents:
  - Not cleared by load_start.
  - Addresses >= LEN keep their previous contents.
  - Bytes written before an ERR remain in memory; the CPU stays in reset.
- fetch_inst is always combinational from mem[fetch_pc]. A read and write to the same address in the same cycle returns the old value; the new value is visible after the edge.
- in_valid with in_ready=0: no transfer, no state change.
- Reset mid-frame: immediate abort; all state returns to reset values, including memory=0.
- Only in_data/in_valid are sampled; upstream holds them stable while in_ready=0.

Optional Feature:
- Macro: CPU_SIMPLE_LOADER_TIMEOUT_EN.
- Enabled:
  - A counter clears on every accepted byte and on entering LEN.
  - It increments each cycle spent in LEN, DATA or CSUM without a transfer.
  - Reaching TIMEOUT-1 -> ERR on the next edge.
  - A transfer in the same cycle as expiry wins: the byte is processed and the counter clears.
- Disabled: no counter; the loader waits indefinitely within a frame.

Decomposition:
- Shared package cpu_simple_pkg holds:
  - the state encoding localparams (HDR, LEN, DATA, CSUM, DONE, ERR);
  - SYNC_BYTE default;
  - IMEM depth/width constants reused by cpu_simple.
- One natural sub-module, cpu_simple_imem: 16x8 register file with async clear, one write port, one combinational read port.
- The FSM, checksum and timeout stay in the loader.

Test Plan:
- Good load: A5,04,11,22,44,88,FF after reset (11^22^44^88=FF) -> load_done=1 and cpu_rst=0 one edge after FF; fetch_pc=0..3 -> 11,22,44,88; fetch_pc=4 -> 00.
- Bad checksum: A5,02,10,20,31 -> load_err=1, cpu_rst stays 1, in_ready=0; then load_start, A5,01,7E,7E -> load_done=1 and fetch_pc=0 -> 7E, fetch_pc=1 -> 20 (left from the failed frame).
- Length errors:
  - A5,00 -> load_err=1.
  - A5,11 -> load_err=1.
  - Leading garbage 00,FF,A5,01,5A,5A -> garbage ignored, load_done=1.
- Backpressure/gaps: random in_valid drops during a 16-byte frame (data=index, CSUM=00) -> mem[i]=i; in DONE, in_valid=1 causes no transfer.
- Async reset mid-DATA after 3 bytes -> outputs return to reset values without a clock edge; fetch_inst=00 for all PCs.
- Timeout (feature enabled, TIMEOUT=64): A5,03,01, then idle 64 cycles -> load_err=1. With feature disabled, same stimulus -> still in DATA and in_ready=1.

Source files
------------

// File: rtl/cpu_simple_pkg.sv
// Shared constants for cpu_simple and its instruction-memory loader:
// IMEM geometry, default frame sync byte, and the loader state encoding.
package cpu_simple_pkg;

   localparam int IMEM_AW    = 4;
   localparam int IMEM_DW    = 8;
   localparam int IMEM_DEPTH = 1 << IMEM_AW;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      ST_HDR  = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } loader_state_e;

endpackage

// File: rtl/cpu_simple_imem.sv
// Instruction register file: async clear, one synchronous write port and one
// combinational read port (a same-cycle read of a written word sees the old value).
module cpu_simple_imem
   import cpu_simple_pkg::*;
#(
   parameter int AW = IMEM_AW,
   parameter int DW = IMEM_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu_simple_imem_loader.sv
// Framed byte-stream loader for cpu_simple's IMEM; holds the CPU in reset until a
// frame passes its XOR checksum. Define CPU_SIMPLE_LOADER_TIMEOUT_EN for an in-frame idle timeout.
module cpu_simple_imem_loader
   import cpu_simple_pkg::*;
#(
   parameter int               ADDR_W    = IMEM_AW,
   parameter int               DATA_W    = IMEM_DW,
   parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(SYNC_BYTE_DEF),
   parameter int               TIMEOUT   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] fetch_pc,
   output logic [DATA_W-1:0] fetch_inst,
   output logic              cpu_rst,
   output logic              load_done,
   output logic              load_err,
   output loader_state_e     dbg_state
);

   localparam int DEPTH = 1 << ADDR_W;

   // Handshake: a byte transfers on a rising clk where in_valid and in_ready are both 1;
   // in_ready depends only on the registered state, never on in_valid.
   loader_state_e     state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              xfer, len_ok, last_byte, mem_we;

   assign in_ready  = (state_q == ST_HDR) || (state_q == ST_LEN) ||
                      (state_q == ST_DATA) || (state_q == ST_CSUM);
   assign xfer      = in_valid & in_ready;
   assign len_ok    = (in_data != '0) && (32'(in_data) <= 32'(DEPTH));
   assign last_byte = ({1'b0, ptr_q} == (len_q - (ADDR_W+1)'(1)));

`ifdef CPU_SIMPLE_LOADER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`else
   // Timeout is compiled out; keep TIMEOUT referenced so both builds elaborate alike.
   if (TIMEOUT < 1) begin : g_timeout_unused
   end
`endif

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      ptr_d   = ptr_q;
      acc_d   = acc_q;
      mem_we  = 1'b0;
      case (state_q)
         ST_HDR: begin
            if (xfer && (in_data == SYNC_BYTE)) state_d = ST_LEN;
         end
         ST_LEN: begin
            if (xfer) begin
               if (len_ok) begin
                  len_d   = in_data[ADDR_W:0];
                  ptr_d   = '0;
                  acc_d   = '0;
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               mem_we = 1'b1;
               acc_d  = acc_q ^ in_data;
               ptr_d  = ptr_q + ADDR_W'(1);
               if (last_byte) state_d = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (xfer) state_d = (in_data == acc_q) ? ST_DONE : ST_ERR;
         end
         ST_DONE, ST_ERR: begin
            if (load_start) state_d = ST_HDR;
         end
         default: state_d = ST_HDR;
      endcase
`ifdef CPU_SIMPLE_LOADER_TIMEOUT_EN
      // A transfer always clears the counter, so it wins over a same-cycle expiry.
      tmo_d = '0;
      if (((state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM)) && !xfer) begin
         if (tmo_q == TMO_W'(TIMEOUT - 1)) state_d = ST_ERR;
         else                              tmo_d   = tmo_q + TMO_W'(1);
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_HDR;
         len_q   <= '0;
         ptr_q   <= '0;
         acc_q   <= '0;
`ifdef CPU_SIMPLE_LOADER_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         ptr_q   <= ptr_d;
         acc_q   <= acc_d;
`ifdef CPU_SIMPLE_LOADER_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   // Status outputs decode the state register directly, so they change only on clk or rst.
   assign load_done = (state_q == ST_DONE);
   assign load_err  = (state_q == ST_ERR);
   assign cpu_rst   = (state_q != ST_DONE);
   assign dbg_state = state_q;

   cpu_simple_imem #(
      .AW (ADDR_W),
      .DW (DATA_W)
   ) u_imem (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (ptr_q),
      .wdata (in_data),
      .raddr (fetch_pc),
      .rdata (fetch_inst)
   );

endmodule

// File: tb/tb_cpu_simple_imem_loader.sv
// Self-checking bench for cpu_simple_imem_loader: frame vector table, memory
// scoreboard, backpressure, async reset mid-frame and idle timeout.
module tb_cpu_simple_imem_loader;
   import cpu_simple_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          load_start;
   logic [3:0]    fetch_pc;
   logic [7:0]    fetch_inst;
   logic          cpu_rst;
   logic          load_done;
   logic          load_err;
   loader_state_e dbg_state;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   cpu_simple_imem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .load_start (load_start),
      .fetch_pc   (fetch_pc),
      .fetch_inst (fetch_inst),
      .cpu_rst    (cpu_rst),
      .load_done  (load_done),
      .load_err   (load_err),
      .dbg_state  (dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // frame table: bytes packed MSB-first, expected status, memory probes
   typedef struct {
      logic [63:0] bytes;
      int          nbytes;
      logic        exp_done;
      logic        exp_err;
      int          nchk;
      logic [19:0] pcs;
      logic [39:0] vals;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic mem_check(input logic [3:0] pc, input logic [7:0] val);
      logic [7:0] e;
      exp_q.push_back(val);
      fetch_pc = pc;
      #1;
      e = exp_q.pop_front();
      chk($sformatf("mem[%0d]", pc), {24'h0, fetch_inst}, {24'h0, e});
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that took the byte.
   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int gap;
      int t;
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom_range(255, 0));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (!in_ready && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_ready actual=0 required=1 byte=%0h", b);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      @(posedge clk);
      #1;
      load_start = 1'b0;
   endtask

   initial begin
      vecs[0] = '{64'hA504_1122_4488_FF00, 7, 1'b1, 1'b0, 5, 20'h01234, 40'h11_22_44_88_00};
      vecs[1] = '{64'hA502_1020_3100_0000, 5, 1'b0, 1'b1, 2, 20'h01000, 40'h10_20_00_00_00};
      vecs[2] = '{64'hA501_7E7E_0000_0000, 4, 1'b1, 1'b0, 3, 20'h01200, 40'h7E_20_44_00_00};
      vecs[3] = '{64'hA500_0000_0000_0000, 2, 1'b0, 1'b1, 1, 20'h00000, 40'h7E_00_00_00_00};
      vecs[4] = '{64'hA511_0000_0000_0000, 2, 1'b0, 1'b1, 1, 20'h00000, 40'h7E_00_00_00_00};
      vecs[5] = '{64'h00FF_A501_5A5A_0000, 6, 1'b1, 1'b0, 2, 20'h01000, 40'h5A_20_00_00_00};

      // reset block
      rst        = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      load_start = 1'b0;
      fetch_pc   = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cpu_rst", {31'h0, cpu_rst}, 32'd1);
      chk("rst_done", {31'h0, load_done}, 32'd0);
      chk("rst_err", {31'h0, load_err}, 32'd0);
      mem_check(4'd0, 8'h00);
      mem_check(4'd15, 8'h00);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
      chk("rst_state", 32'(dbg_state), 32'(ST_HDR));

      // table-driven frames
      for (int v = 0; v < 6; v++) begin
         if (v != 0) begin
            pulse_start();
            chk("start_done_clr", {31'h0, load_done}, 32'd0);
            chk("start_err_clr", {31'h0, load_err}, 32'd0);
            chk("start_cpu_rst", {31'h0, cpu_rst}, 32'd1);
         end
         for (int i = 0; i < vecs[v].nbytes; i++)
            send_byte(vecs[v].bytes[63-8*i -: 8], 0);
         chk($sformatf("v%0d_done", v), {31'h0, load_done}, {31'h0, vecs[v].exp_done});
         chk($sformatf("v%0d_err", v), {31'h0, load_err}, {31'h0, vecs[v].exp_err});
         chk($sformatf("v%0d_cpu_rst", v), {31'h0, cpu_rst}, {31'h0, !vecs[v].exp_done});
         chk($sformatf("v%0d_in_ready", v), {31'h0, in_ready}, 32'd0);
         for (int k = 0; k < vecs[v].nchk; k++)
            mem_check(vecs[v].pcs[19-4*k -: 4], vecs[v].vals[39-8*k -: 8]);
      end

      // 16-byte frame with random valid gaps, data = index, checksum 00
      pulse_start();
      send_byte(8'hA5, 3);
      send_byte(8'h10, 3);
      for (int i = 0; i < 16; i++) send_byte(8'(i), 3);
      send_byte(8'h00, 3);
      chk("bp_done", {31'h0, load_done}, 32'd1);
      chk("bp_cpu_rst", {31'h0, cpu_rst}, 32'd0);
      for (int i = 0; i < 16; i++) mem_check(4'(i), 8'(i));

      // in DONE, offered bytes must not transfer
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (3) @(posedge clk);
      #1;
      chk("done_in_ready", {31'h0, in_ready}, 32'd0);
      chk("done_hold", {31'h0, load_done}, 32'd1);
      chk("done_state", 32'(dbg_state), 32'(ST_DONE));
      in_valid = 1'b0;
      mem_check(4'd0, 8'h00);

      // async reset after 3 data bytes, checked before any clock edge
      pulse_start();
      send_byte(8'hA5, 0);
      send_byte(8'h05, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      send_byte(8'hCC, 0);
      chk("mid_state", 32'(dbg_state), 32'(ST_DATA));
      rst = 1'b0;
      #1;
      chk("arst_cpu_rst", {31'h0, cpu_rst}, 32'd1);
      chk("arst_done", {31'h0, load_done}, 32'd0);
      chk("arst_err", {31'h0, load_err}, 32'd0);
      chk("arst_state", 32'(dbg_state), 32'(ST_HDR));
      for (int i = 0; i < 16; i++) mem_check(4'(i), 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // idle inside a frame
      send_byte(8'hA5, 0);
      send_byte(8'h03, 0);
      send_byte(8'h01, 0);
      repeat (63) @(posedge clk);
      #1;
`ifdef CPU_SIMPLE_LOADER_TIMEOUT_EN
      chk("tmo_early_err", {31'h0, load_err}, 32'd0);
      @(posedge clk);
      #1;
      chk("tmo_err", {31'h0, load_err}, 32'd1);
      chk("tmo_in_ready", {31'h0, in_ready}, 32'd0);
      chk("tmo_cpu_rst", {31'h0, cpu_rst}, 32'd1);
`else
      @(posedge clk);
      #1;
      repeat (10) @(posedge clk);
      #1;
      chk("notmo_err", {31'h0, load_err}, 32'd0);
      chk("notmo_in_ready", {31'h0, in_ready}, 32'd1);
      chk("notmo_state", 32'(dbg_state), 32'(ST_DATA));
`endif
      mem_check(4'd0, 8'h01);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
